// File: rtl/gray_conv_rr_scheduler_pkg.sv
// Shared constants and helpers for the round-robin Gray-code scheduler.
package gray_sched_pkg;

    localparam int N_DEF       = 8;
    localparam int NUM_REQ_DEF = 4;

    // Index width that never collapses to zero bits
    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/gray_conv_rr_scheduler_if.sv
// Requester and downstream handshake bundle for the Gray-code scheduler.
interface gray_conv_rr_scheduler_if #(
    parameter int N       = gray_sched_pkg::N_DEF,
    parameter int NUM_REQ = gray_sched_pkg::NUM_REQ_DEF
);
    import gray_sched_pkg::*;

    localparam int ID_W = clog2_safe(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out_gray;
    logic [ID_W-1:0]      out_id;

    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_gray, out_id
    );

    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_gray, out_id
    );

endinterface

// File: rtl/binary_to_graycode.sv
// Combinational N-bit binary to reflected Gray code converter.
module binary_to_graycode #(
    parameter int N = 8
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; searches from last+1 upward with wrap.
module rr_arbiter
    import gray_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]                 req,
    input  logic                               en,
    input  logic [clog2_safe(NUM_REQ)-1:0]     last,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [clog2_safe(NUM_REQ)-1:0]     grant_idx
);

    localparam int IW = clog2_safe(NUM_REQ);

    typedef logic [IW:0] wide_t;

    wide_t idx;
    logic  found;

    // Extra bit keeps last+k exact before the modulo for any NUM_REQ
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last} + wide_t'(k);
            if (idx >= wide_t'(NUM_REQ)) begin
                idx = idx - wide_t'(NUM_REQ);
            end
            if (en && !found && req[idx[IW-1:0]]) begin
                found                 = 1'b1;
                grant[idx[IW-1:0]]    = 1'b1;
                grant_idx             = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/gray_conv_rr_scheduler.sv
// Round-robin sharing of one binary-to-Gray converter among NUM_REQ clients,
// with a single registered output slot tagged by requester index.
module gray_conv_rr_scheduler
    import gray_sched_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input logic                      clk,
    input logic                      rst,
    gray_conv_rr_scheduler_if.master bus
);

    localparam int ID_W = clog2_safe(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    rr_last;
    logic               load;
    logic               accept;
    logic [N-1:0]       sel_data;
    logic [N-1:0]       sel_gray;
    logic               valid_q;
    logic [N-1:0]       gray_q;
    logic [ID_W-1:0]    id_q;

    assign load = ~valid_q | bus.out_ready;

    // Gating with rst keeps req_ready low for the whole reset pulse
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .en        (load & ~rst),
        .last      (rr_last),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept   = |grant;
    assign sel_data = bus.req_data[grant_idx*N +: N];

    binary_to_graycode #(.N(N)) u_conv (
        .bin  (sel_data),
        .gray (sel_gray)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            gray_q  <= '0;
            id_q    <= '0;
            rr_last <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            valid_q <= 1'b1;
            gray_q  <= sel_gray;
            id_q    <= grant_idx;
            rr_last <= grant_idx;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = valid_q;
    assign bus.out_gray  = gray_q;
    assign bus.out_id    = id_q;

endmodule
